obstacle_spawner: RTL
=====================

// Module: obstacle_spawner
//
// PURPOSE
// Downstream consumer of the random obstacle-position generator. Counts video
// frames and, every SPAWN_PERIOD frames, pulses the generator's rise input.
// It then captures the returned random value, maps it to a clamped screen X
// coordinate and allocates it to the lowest free obstacle slot.
// The slot table (active bits + X) feeds the obstacle drawing/motion blocks.
//
// PARAMETERS
// NUM_SLOTS     4    number of obstacle slots (1..8)
// SIZE_BITS     8    width of rand_value from the random generator
// X_BITS        11   width of screen X coordinate per slot
// SPAWN_PERIOD  60   frames between spawn attempts (>=1)
// X_MIN         16   X offset added to rand_value
// X_MAX         600  upper clamp for computed X
//
// PORTS
// clk           in   1                    system clock
// reset         in   1                    synchronous, active-high reset
// startOfFrame  in   1                    one-cycle pulse per video frame
// enable        in   1                    1 = frame counting / spawning allowed
// rand_value    in   SIZE_BITS            random generator output (dout)
// slot_clear    in   NUM_SLOTS            per-slot free request (hit/exit)
// spawn_req     out  1                    drives generator rise input
// spawn_pulse   out  1                    1-cycle strobe: slot allocated
// spawn_slot    out  3                    index allocated, valid with spawn_pulse
// slot_active   out  NUM_SLOTS            slot occupied flags
// slot_x        out  NUM_SLOTS*X_BITS     packed X per slot, slot0 = LSBs
// drop_count    out  8                    spawns lost to full table, saturating
//
// BEHAVIOUR
// - Reset (sync, clk edge with reset=1): every output is 0, including
//   spawn_req, slot_active, slot_x and drop_count. Frame counter = 0,
//   pending = 0, FSM = IDLE. Reset aborts any sequence mid-flight.
// - Frame counter: increments on startOfFrame only while enable=1; held otherwise.
//   On a pulse with count==SPAWN_PERIOD-1 -> count=0 and a trigger is raised.
// - pending flag: set by trigger; cleared on IDLE->REQ. Holds at most one
//   trigger; extra triggers while pending=1 are discarded.
// - FSM: IDLE -> REQ when pending=1 or a trigger arrives this cycle.
//   REQ (2 cycles, spawn_req=1) -> WAIT (1 cycle, spawn_req=0) -> CAPTURE
//   -> ALLOC -> IDLE.
// - The generator updates dout one cycle after it sees the rise edge, so
//   rand_value is registered in CAPTURE only: 3 cycles after REQ entry.
// - Map: x = X_MIN + zero-extend(rand_value), computed in X_BITS+1 bits;
//   if x > X_MAX then x = X_MAX.
// - enable=0 mid-sequence: current sequence completes; no new REQ while
//   enable=0, but pending is kept.
// - slot_clear[k]=1: slot_active[k] <= 0 next edge. slot_x[k] keeps its value.
// - ALLOC: slot_clear is applied first, so a slot cleared this cycle counts as
//   free. The lowest free index k gets slot_active[k]<=1 and slot_x[k]<=x.
//   spawn_pulse=1 and spawn_slot=k for that one cycle (registered).
//   If clear and allocate hit the same slot, set wins.
// - ALLOC with no free slot: no slot change, spawn_pulse=0,
//   drop_count+1, saturating at 255.
// - spawn_slot holds its last value when spawn_pulse=0.
// - End-to-end latency: trigger edge -> spawn_pulse is 5 cycles
//   (REQ, REQ, WAIT, CAPTURE, ALLOC).
//
// TESTING
// 1 SPAWN_PERIOD=3, enable=1, 3 frame pulses -> spawn_req high exactly 2
//   cycles; rand_value=40 -> slot0 active, slot_x[0]=56, spawn_slot=0.
// 2 rand_value=255, X_MIN=16, X_MAX=200 -> slot_x=200 (clamp);
//   rand_value=0 -> slot_x=16.
// 3 All 4 slots active, trigger -> no slot change, drop_count 0->1;
//   preload 255, repeat -> stays 255.
// 4 Slots 0,1 active; slot_clear[0] asserted in ALLOC cycle
//   -> slot0 re-allocated, active=1, new X, spawn_slot=0.
// 5 Two triggers during one sequence -> exactly one extra sequence follows,
//   spawn_req pulses twice in total.
// 6 reset asserted during WAIT -> next cycle all outputs 0, FSM IDLE;
//   no spawn_pulse until a full SPAWN_PERIOD elapses.

Source files
------------

// File: rtl/obstacle_spawner_if.sv
// Bus between the obstacle spawner and its environment: frame timing, random
// generator handshake, slot-clear requests and the published slot table.
interface obstacle_spawner_if #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SIZE_BITS = 8,
    parameter int unsigned X_BITS    = 11
);
    logic                        startOfFrame;
    logic                        enable;
    logic [SIZE_BITS-1:0]        rand_value;
    logic [NUM_SLOTS-1:0]        slot_clear;
    logic                        spawn_req;
    logic                        spawn_pulse;
    logic [2:0]                  spawn_slot;
    logic [NUM_SLOTS-1:0]        slot_active;
    logic [NUM_SLOTS*X_BITS-1:0] slot_x;
    logic [7:0]                  drop_count;

    // Environment side: drives frame timing, random value and clears.
    modport master (
        output startOfFrame, enable, rand_value, slot_clear,
        input  spawn_req, spawn_pulse, spawn_slot, slot_active, slot_x, drop_count
    );

    // Spawner side.
    modport slave (
        input  startOfFrame, enable, rand_value, slot_clear,
        output spawn_req, spawn_pulse, spawn_slot, slot_active, slot_x, drop_count
    );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: counts frames, requests a random value every SPAWN_PERIOD
// frames, maps it to a clamped X coordinate and places it in the lowest free slot.
module obstacle_spawner #(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned SIZE_BITS    = 8,
    parameter int unsigned X_BITS       = 11,
    parameter int unsigned SPAWN_PERIOD = 60,
    parameter int unsigned X_MIN        = 16,
    parameter int unsigned X_MAX        = 600
) (
    input logic               clk,
    input logic               reset,
    obstacle_spawner_if.slave bus
);
    localparam int unsigned     CntW    = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SPAWN_PERIOD - 1);
    localparam logic [X_BITS:0] XMin    = (X_BITS + 1)'(X_MIN);
    localparam logic [X_BITS:0] XMax    = (X_BITS + 1)'(X_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StReq1,
        StReq2,
        StWait,
        StCapture,
        StAlloc
    } state_e;

    state_e                      state_q, state_d;
    logic [CntW-1:0]             frame_cnt_q, frame_cnt_d;
    logic                        pending_q, pending_d;
    logic [SIZE_BITS-1:0]        rand_q, rand_d;
    logic [NUM_SLOTS-1:0]        active_q, active_d;
    logic [NUM_SLOTS*X_BITS-1:0] slot_x_q, slot_x_d;
    logic                        pulse_q, pulse_d;
    logic [2:0]                  slot_q, slot_d;
    logic [7:0]                  drop_q, drop_d;

    logic                        trigger;
    logic                        start_seq;
    logic [X_BITS:0]             x_sum;
    logic [X_BITS-1:0]           x_clamped;
    logic [NUM_SLOTS-1:0]        free;
    logic [NUM_SLOTS-1:0]        free_oh;
    logic                        found;
    logic [2:0]                  free_idx;

    // Frame counter; the wrap on the last frame of a period is the spawn trigger.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        trigger     = 1'b0;
        if (bus.startOfFrame && bus.enable) begin
            if (frame_cnt_q == CntLast) begin
                frame_cnt_d = '0;
                trigger     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + CntW'(1);
            end
        end
    end

    // Sequence FSM and the single-entry pending trigger.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        start_seq = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable && (pending_q || trigger)) begin
                    state_d   = StReq1;
                    start_seq = 1'b1;
                end
            end
            StReq1:    state_d = StReq2;
            StReq2:    state_d = StWait;
            StWait:    state_d = StCapture;
            StCapture: state_d = StAlloc;
            StAlloc:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // A trigger coinciding with sequence start is absorbed by that sequence.
        if (start_seq) begin
            pending_d = 1'b0;
        end else if (trigger) begin
            pending_d = 1'b1;
        end
    end

    // Map captured random value to a clamped X coordinate.
    always_comb begin
        x_sum     = XMin + (X_BITS + 1)'(rand_q);
        x_clamped = (x_sum > XMax) ? XMax[X_BITS-1:0] : x_sum[X_BITS-1:0];
    end

    // Slot table: clears apply every cycle, allocation sees cleared slots as free.
    always_comb begin
        free     = ~active_q | bus.slot_clear;
        found    = 1'b0;
        free_idx = 3'd0;
        free_oh  = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (free[k]) begin
                found      = 1'b1;
                free_idx   = 3'(k);
                free_oh    = '0;
                free_oh[k] = 1'b1;
            end
        end

        rand_d   = rand_q;
        active_d = active_q & ~bus.slot_clear;
        slot_x_d = slot_x_q;
        pulse_d  = 1'b0;
        slot_d   = slot_q;
        drop_d   = drop_q;
        if (state_q == StCapture) begin
            rand_d = bus.rand_value;
        end
        if (state_q == StAlloc) begin
            if (found) begin
                active_d = active_d | free_oh;
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (free_oh[k]) begin
                        slot_x_d[k*X_BITS +: X_BITS] = x_clamped;
                    end
                end
                pulse_d = 1'b1;
                slot_d  = free_idx;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            pending_q   <= 1'b0;
            rand_q      <= '0;
            active_q    <= '0;
            slot_x_q    <= '0;
            pulse_q     <= 1'b0;
            slot_q      <= 3'd0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
            rand_q      <= rand_d;
            active_q    <= active_d;
            slot_x_q    <= slot_x_d;
            pulse_q     <= pulse_d;
            slot_q      <= slot_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.spawn_req   = (state_q == StReq1) || (state_q == StReq2);
    assign bus.spawn_pulse = pulse_q;
    assign bus.spawn_slot  = slot_q;
    assign bus.slot_active = active_q;
    assign bus.slot_x      = slot_x_q;
    assign bus.drop_count  = drop_q;
endmodule
